// File: rtl/npu_config_sequencer.sv
// Config FIFO drain and PE weight loader: decodes header/weight/commit words, one word per 4 cycles.
// Optional empty-FIFO watchdog while weights are pending: define CFG_TIMEOUT_EN.
module npu_config_sequencer #(
  parameter int NUM_PE      = 8,
  parameter int WADDR_W     = 6,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [25:0]        cfg_fifo_data,
  input  logic               cfg_fifo_empty,
  output logic               cfg_fifo_read_enable,
  input  logic               npu_busy,
  output logic               pe_wr_en,
  output logic [NUM_PE-1:0]  pe_wr_sel,
  output logic [WADDR_W-1:0] pe_wr_addr,
  output logic [DATA_W-1:0]  pe_wr_data,
  output logic               cfg_done,
  output logic               cfg_error,
  output logic               cfg_busy
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_EXEC} state_t;

  state_t               r_state;
  logic [6:0]           r_remaining;
  logic [WADDR_W-1:0]   r_addr;
  logic [2:0]           r_pe_id;
  logic                 r_wr_en;
  logic [NUM_PE-1:0]    r_wr_sel;
  logic [WADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]    r_wr_data;
  logic                 r_done;
  logic                 r_error;

  logic [1:0]           w_opcode;
  logic [2:0]           w_hdr_pe;
  logic [5:0]           w_hdr_cm1;
  logic [DATA_W-1:0]    w_data;
  logic                 w_pe_ok;
  logic                 w_pending;
  logic                 w_start;
  logic                 w_to_fire;
  logic [NUM_PE-1:0]    w_sel;

  assign w_opcode  = cfg_fifo_data[25:24];
  assign w_hdr_pe  = cfg_fifo_data[23:21];
  assign w_hdr_cm1 = cfg_fifo_data[20:15];
  assign w_data    = cfg_fifo_data[DATA_W-1:0];
  assign w_pe_ok   = (32'(w_hdr_pe) < NUM_PE);
  assign w_pending = (r_remaining != 7'd0);
  assign w_start   = (r_state == S_IDLE) && !cfg_fifo_empty && !npu_busy;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_sel
      assign w_sel[gi] = (32'(r_pe_id) == gi);
    end
  endgenerate

`ifdef CFG_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            w_to_count;

  // Only counts idle cycles spent starved of data while a load is still open.
  assign w_to_count = (r_state == S_IDLE) && w_pending && cfg_fifo_empty;
  assign w_to_fire  = w_to_count && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_to_cnt <= '0;
    end else if (w_start || w_to_fire) begin
      r_to_cnt <= '0;
    end else if (w_to_count) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  assign w_to_fire = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_addr      <= '0;
      r_pe_id     <= '0;
      r_wr_en     <= 1'b0;
      r_wr_sel    <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_wr_en  <= 1'b0;
      r_wr_sel <= '0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_FETCH;
          end else if (w_to_fire) begin
            r_error     <= 1'b1;
            r_remaining <= '0;
          end
        end
        S_FETCH: r_state <= cfg_fifo_empty ? S_IDLE : S_WAIT;
        // Word is valid now; decode here so the strobes are registered into the EXEC cycle.
        S_WAIT: begin
          r_state <= S_EXEC;
          case (w_opcode)
            2'b01: begin
              if (!w_pe_ok) begin
                r_error <= 1'b1;
              end else begin
                if (w_pending) r_error <= 1'b1;
                r_pe_id     <= w_hdr_pe;
                r_addr      <= '0;
                r_remaining <= {1'b0, w_hdr_cm1} + 7'd1;
              end
            end
            2'b10: begin
              if (w_pending) begin
                r_wr_en     <= 1'b1;
                r_wr_sel    <= w_sel;
                r_wr_addr   <= r_addr;
                r_wr_data   <= w_data;
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 7'd1;
              end else begin
                r_error <= 1'b1;
              end
            end
            2'b11: begin
              r_done <= 1'b1;
              if (w_pending) begin
                r_error     <= 1'b1;
                r_remaining <= '0;
              end
            end
            default: ;
          endcase
        end
        S_EXEC: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cfg_fifo_read_enable = (r_state == S_FETCH) && !cfg_fifo_empty;
  assign pe_wr_en   = r_wr_en;
  assign pe_wr_sel  = r_wr_sel;
  assign pe_wr_addr = r_wr_addr;
  assign pe_wr_data = r_wr_data;
  assign cfg_done   = r_done;
  assign cfg_error  = r_error;
  assign cfg_busy   = w_pending || (r_state != S_IDLE);

endmodule

// File: tb/tb_npu_config_sequencer.sv
// Directed bench for npu_config_sequencer with a behavioural config FIFO and a write logger.
// Six PEs leave pe_id codes 6 and 7 unused so out-of-range headers can be exercised.
module tb_npu_config_sequencer;
  localparam int NPE = 6;
  localparam int AW  = 6;
  localparam int DW  = 16;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [25:0]     fifo_data = '0;
  logic            fifo_empty;
  logic            rd_en;
  logic            npu_busy = 1'b0;
  logic            wr_en;
  logic [NPE-1:0]  wr_sel;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            done;
  logic            err;
  logic            busy;

  always #5 CLK = ~CLK;

  npu_config_sequencer #(
    .NUM_PE(NPE), .WADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)
  ) dut (
    .CLK(CLK), .RST(RST),
    .cfg_fifo_data(fifo_data), .cfg_fifo_empty(fifo_empty),
    .cfg_fifo_read_enable(rd_en), .npu_busy(npu_busy),
    .pe_wr_en(wr_en), .pe_wr_sel(wr_sel), .pe_wr_addr(wr_addr), .pe_wr_data(wr_data),
    .cfg_done(done), .cfg_error(err), .cfg_busy(busy)
  );

  // Config FIFO model: pushed by the stimulus, popped on read enable.
  logic [25:0] mem [0:511];
  int wp = 0;
  int rp = 0;
  assign fifo_empty = (wp == rp);

  always @(posedge CLK) begin
    if (rd_en === 1'b1) begin
      fifo_data <= mem[rp];
      rp <= rp + 1;
    end
  end

  // Write/commit logger plus protocol-violation counter.
  logic [NPE-1:0] log_sel  [0:255];
  logic [AW-1:0]  log_addr [0:255];
  logic [DW-1:0]  log_data [0:255];
  int wcnt = 0;
  int done_cnt = 0;
  int viol = 0;

  always @(negedge CLK) begin
    if (wr_en === 1'b1) begin
      log_sel[wcnt]  <= wr_sel;
      log_addr[wcnt] <= wr_addr;
      log_data[wcnt] <= wr_data;
      wcnt <= wcnt + 1;
      $display("write sel=%b addr=%0d data=%h", wr_sel, wr_addr, wr_data);
    end
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if ((wr_en === 1'b1 && done === 1'b1) || (rd_en === 1'b1 && fifo_empty))
      viol <= viol + 1;
  end

  int n_asrt = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] hdr(input int pe, input int cm1);
    return {2'b01, 3'(pe), 6'(cm1), 15'd0};
  endfunction

  function automatic logic [25:0] wgt(input int d);
    return {2'b10, 8'd0, 16'(d)};
  endfunction

  localparam logic [25:0] COMMIT = {2'b11, 24'd0};
  localparam logic [25:0] NOP    = 26'd0;

  task automatic push(input logic [25:0] w);
    mem[wp] = w;
    wp = wp + 1;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (wp != rp && k < 600) begin
      @(negedge CLK);
      k++;
    end
    check(tag, 32'(wp == rp), 32'd1);
    repeat (5) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
  endtask

  int b;
  int d;
  int cnt;

  initial begin
    // T1: reset with data waiting in the FIFO
    push(NOP);
    repeat (5) begin
      @(negedge CLK);
      check("t1_ctrl_zero", 32'({rd_en, wr_en, done, err, busy, wr_sel}), 32'd0);
      check("t1_bus_zero", 32'({wr_addr, wr_data}), 32'd0);
    end
    RST = 1'b0;
    @(negedge CLK);
    check("t1_first_rd", 32'(rd_en), 32'd1);
    drain("t1_drain");

    // T2: normal three-word load then commit
    b = wcnt; d = done_cnt;
    push(hdr(2, 2)); push(wgt(16'h1111)); push(wgt(16'h2222)); push(wgt(16'h3333)); push(COMMIT);
    drain("t2_drain");
    check("t2_nwrites", 32'(wcnt - b), 32'd3);
    check("t2_w0", 32'({log_sel[b],   log_addr[b],   log_data[b]}),   32'({6'b000100, 6'd0, 16'h1111}));
    check("t2_w1", 32'({log_sel[b+1], log_addr[b+1], log_data[b+1]}), 32'({6'b000100, 6'd1, 16'h2222}));
    check("t2_w2", 32'({log_sel[b+2], log_addr[b+2], log_data[b+2]}), 32'({6'b000100, 6'd2, 16'h3333}));
    check("t2_done", 32'(done_cnt - d), 32'd1);
    check("t2_err", 32'(err), 32'd0);
    check("t2_busy", 32'(busy), 32'd0);

    // T3: npu_busy holds off fetching
    npu_busy = 1'b1;
    push(NOP); push(NOP);
    cnt = 0;
    repeat (20) begin
      @(negedge CLK);
      if (rd_en === 1'b1) cnt++;
    end
    check("t3_no_rd", cnt, 32'd0);
    npu_busy = 1'b0;
    @(negedge CLK);
    check("t3_rd_after", 32'(rd_en), 32'd1);
    drain("t3_drain");

    // T4a: stray weight
    do_reset();
    b = wcnt;
    push(wgt(16'h5555));
    drain("t4a_drain");
    check("t4a_nwrites", 32'(wcnt - b), 32'd0);
    check("t4a_err", 32'(err), 32'd1);

    // T4b: header for a PE that does not exist
    do_reset();
    b = wcnt;
    check("t4b_err_clr", 32'(err), 32'd0);
    push(hdr(7, 0)); push(wgt(16'h7777));
    drain("t4b_drain");
    check("t4b_nwrites", 32'(wcnt - b), 32'd0);
    check("t4b_err", 32'(err), 32'd1);

    // T4c: early commit
    do_reset();
    b = wcnt; d = done_cnt;
    push(hdr(1, 1)); push(wgt(16'hABCD)); push(COMMIT);
    drain("t4c_drain");
    check("t4c_nwrites", 32'(wcnt - b), 32'd1);
    check("t4c_done", 32'(done_cnt - d), 32'd1);
    check("t4c_err", 32'(err), 32'd1);
    check("t4c_busy", 32'(busy), 32'd0);

    // T4d: header while a load is open replaces it
    do_reset();
    b = wcnt; d = done_cnt;
    push(hdr(3, 5)); push(hdr(4, 0)); push(wgt(16'h4444)); push(COMMIT);
    drain("t4d_drain");
    check("t4d_nwrites", 32'(wcnt - b), 32'd1);
    check("t4d_w0", 32'({log_sel[b], log_addr[b], log_data[b]}), 32'({6'b010000, 6'd0, 16'h4444}));
    check("t4d_done", 32'(done_cnt - d), 32'd1);
    check("t4d_err", 32'(err), 32'd1);

    // T5: full 64-word load across the whole address space
    do_reset();
    b = wcnt; d = done_cnt;
    push(hdr(0, 63));
    for (int i = 0; i < 64; i++) push(wgt(16'hA000 + i));
    drain("t5_drain");
    check("t5_nwrites", 32'(wcnt - b), 32'd64);
    for (int i = 0; i < 64; i++)
      check("t5_write", 32'({log_sel[b+i], log_addr[b+i], log_data[b+i]}),
            32'({6'b000001, 6'(i), 16'(16'hA000 + i)}));
    check("t5_busy", 32'(busy), 32'd0);
    push(COMMIT);
    drain("t5_commit_drain");
    check("t5_done", 32'(done_cnt - d), 32'd1);
    check("t5_err", 32'(err), 32'd0);
    check("t5_viol", viol, 32'd0);

    // T6: starved open load
    do_reset();
    push(hdr(1, 3));
    cnt = 0;
    while (wp != rp && cnt < 50) begin
      @(negedge CLK);
      cnt++;
    end
    check("t6_popped", 32'(wp == rp), 32'd1);
    repeat (17) @(negedge CLK);
    check("t6_err_before", 32'(err), 32'd0);
    check("t6_busy_before", 32'(busy), 32'd1);
    @(negedge CLK);
`ifdef CFG_TIMEOUT_EN
    check("t6_err_timeout", 32'(err), 32'd1);
    check("t6_busy_timeout", 32'(busy), 32'd0);
`else
    check("t6_err_hold", 32'(err), 32'd0);
    check("t6_busy_hold", 32'(busy), 32'd1);
`endif
    check("t6_viol", viol, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
